// File: rtl/sdm_adc_data_aurora_send.sv
// Aurora TX frame sequencer: pops one wide ADC/TMS_SDM frame from a FWFT FIFO and
// streams it as 63-bit payload beats, with bit 63 marking the last beat of the frame.
module sdm_adc_data_aurora_send #(
  parameter int DIN_WIDTH  = 512,
  parameter int FRAME_BITS = 510
) (
  input  logic                 USER_CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic                 CHANNEL_UP,
  input  logic                 FIFO_EMPTY,
  input  logic [DIN_WIDTH-1:0] FIFO_DOUT,
  output logic                 FIFO_RD_EN,
  output logic [63:0]          S_AXI_TX_TDATA,
  output logic                 S_AXI_TX_TVALID,
  input  logic                 S_AXI_TX_TREADY,
  output logic                 BUSY,
  output logic [31:0]          FRAME_CNT,
  output logic [15:0]          ABORT_CNT
);

  localparam int NBEAT = (FRAME_BITS + 62) / 63;
  localparam int FR_W  = NBEAT * 63;
  localparam logic [3:0] LAST_BEAT = 4'(NBEAT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [FR_W-1:0]   frame_in;
  logic [FR_W-1:0]   frame_p0;
  logic [3:0]        beat_p0;
  logic [3:0]        beat_nxt;
  logic              start;
  logic              hs;
  logic              last;

  // Payload slice for a given beat; the frame register is padded with zeros
  // up to a whole number of beats, so the slice never runs off the end.
  function automatic logic [62:0] beat_slice(input logic [FR_W-1:0] f, input logic [3:0] b);
    return f[63*int'(b) +: 63];
  endfunction

  generate
    if (DIN_WIDTH > FRAME_BITS) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^FIFO_DOUT[DIN_WIDTH-1:FRAME_BITS];
    end
  endgenerate

  always_comb begin
    frame_in                   = '0;
    frame_in[FRAME_BITS-1:0]   = FIFO_DOUT[FRAME_BITS-1:0];
  end

  assign start    = (state == IDLE) && ENABLE && CHANNEL_UP && !FIFO_EMPTY;
  assign hs       = S_AXI_TX_TVALID && S_AXI_TX_TREADY;
  assign last     = (beat_p0 == LAST_BEAT);
  assign beat_nxt = beat_p0 + 4'd1;

  always_ff @(posedge USER_CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // The pop strobe is held off during reset so the FIFO never loses a word
  // that the frame register did not capture.
  always_comb begin
    state_nxt  = state;
    FIFO_RD_EN = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SEND;
          FIFO_RD_EN = !RESET;
        end
      end
      SEND: begin
        if (!CHANNEL_UP)     state_nxt = IDLE;
        else if (hs && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: frame capture and beat presentation
  always_ff @(posedge USER_CLK or posedge RESET) begin
    if (RESET) begin
      frame_p0        <= '0;
      beat_p0         <= '0;
      S_AXI_TX_TDATA  <= '0;
      S_AXI_TX_TVALID <= 1'b0;
      BUSY            <= 1'b0;
      FRAME_CNT       <= '0;
      ABORT_CNT       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            frame_p0        <= frame_in;
            beat_p0         <= '0;
            S_AXI_TX_TDATA  <= {(NBEAT == 1), frame_in[62:0]};
            S_AXI_TX_TVALID <= 1'b1;
            BUSY            <= 1'b1;
          end
        end
        SEND: begin
          // Link loss wins over a same-cycle handshake: the beat is not counted.
          if (!CHANNEL_UP) begin
            S_AXI_TX_TVALID <= 1'b0;
            BUSY            <= 1'b0;
            if (ABORT_CNT != 16'hFFFF) ABORT_CNT <= ABORT_CNT + 16'd1;
          end else if (hs) begin
            if (last) begin
              S_AXI_TX_TVALID <= 1'b0;
              BUSY            <= 1'b0;
              FRAME_CNT       <= FRAME_CNT + 32'd1;
            end else begin
              beat_p0        <= beat_nxt;
              S_AXI_TX_TDATA <= {(beat_nxt == LAST_BEAT), beat_slice(frame_p0, beat_nxt)};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
